// File: rtl/vscale_regmap.sv
// Memory-mapped peripheral block: GPIO, 64-bit machine timer with compare interrupt,
// and a transmit-only 8N1 UART fed by a small FIFO. Read data is registered.
module vscale_regmap #(
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [15:0] UART_DIV_RESET = 16'd868,
    parameter int          GPIO_WIDTH     = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    input  logic                  reg_wen,
    input  logic [13:0]           reg_waddr,
    input  logic [31:0]           reg_wdata,
    input  logic                  reg_ren,
    input  logic [13:0]           reg_raddr,
    output logic [31:0]           reg_rdata,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic                  uart_tx_o,
    output logic                  timer_irq_o
);

    localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [13:0] A_GPIO_OUT = 14'h000;
    localparam logic [13:0] A_GPIO_IN  = 14'h001;
    localparam logic [13:0] A_MT_LO    = 14'h002;
    localparam logic [13:0] A_MT_HI    = 14'h003;
    localparam logic [13:0] A_CMP_LO   = 14'h004;
    localparam logic [13:0] A_CMP_HI   = 14'h005;
    localparam logic [13:0] A_TCTRL    = 14'h006;
    localparam logic [13:0] A_UART_TX  = 14'h008;
    localparam logic [13:0] A_UART_ST  = 14'h009;
    localparam logic [13:0] A_UART_DIV = 14'h00A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    logic [1:0]            rst_sync_q;
    logic                  rst_n;
    logic [GPIO_WIDTH-1:0] gpio_q, gpio_d, gin_s1_q, gin_s2_q;
    logic [63:0]           mtime_q, mtime_d, cmp_q, cmp_d;
    logic                  en_q, en_d, ie_q, ie_d, irq_q, irq_d;
    logic [15:0]           div_q, div_d, div_eff_s;
    logic [31:0]           rdata_q, rdata_d;
    logic [7:0]            fifo_q [FIFO_DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [AW:0]           count_q, count_d;
    logic                  ovf_q, ovf_d;
    uart_state_e           state_q, state_d;
    logic [15:0]           bitcnt_q, bitcnt_d, divlat_q, divlat_d;
    logic [2:0]            bitidx_q, bitidx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  wr_gpio_s, wr_mtlo_s, wr_mthi_s, wr_cmplo_s, wr_cmphi_s;
    logic                  wr_tctrl_s, wr_tx_s, wr_stat_s, wr_div_s;
    logic                  full_s, empty_s, pop_s, push_ok_s;

    // Reset asserts asynchronously but releases two clock edges later
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign wr_gpio_s  = reg_wen && (reg_waddr == A_GPIO_OUT);
    assign wr_mtlo_s  = reg_wen && (reg_waddr == A_MT_LO);
    assign wr_mthi_s  = reg_wen && (reg_waddr == A_MT_HI);
    assign wr_cmplo_s = reg_wen && (reg_waddr == A_CMP_LO);
    assign wr_cmphi_s = reg_wen && (reg_waddr == A_CMP_HI);
    assign wr_tctrl_s = reg_wen && (reg_waddr == A_TCTRL);
    assign wr_tx_s    = reg_wen && (reg_waddr == A_UART_TX);
    assign wr_stat_s  = reg_wen && (reg_waddr == A_UART_ST);
    assign wr_div_s   = reg_wen && (reg_waddr == A_UART_DIV);

    assign full_s    = (count_q == DEPTH_C);
    assign empty_s   = (count_q == '0);
    assign pop_s     = (state_q == S_IDLE) && !empty_s;
    assign push_ok_s = wr_tx_s && (!full_s || pop_s);
    assign div_eff_s = (div_q == 16'd0) ? 16'd1 : div_q;

    always_comb begin
        gpio_d = wr_gpio_s ? reg_wdata[GPIO_WIDTH-1:0] : gpio_q;
        div_d  = wr_div_s ? reg_wdata[15:0] : div_q;
        if (wr_mtlo_s)      mtime_d = {mtime_q[63:32], reg_wdata};
        else if (wr_mthi_s) mtime_d = {reg_wdata, mtime_q[31:0]};
        else if (en_q)      mtime_d = mtime_q + 64'd1;
        else                mtime_d = mtime_q;
        if (wr_cmplo_s)      cmp_d = {cmp_q[63:32], reg_wdata};
        else if (wr_cmphi_s) cmp_d = {reg_wdata, cmp_q[31:0]};
        else                 cmp_d = cmp_q;
        if (wr_tctrl_s) begin
            en_d = reg_wdata[0];
            ie_d = reg_wdata[1];
        end else begin
            en_d = en_q;
            ie_d = ie_q;
        end
        // Compare on next-state values so the registered irq tracks the registers exactly
        irq_d = ie_d && (mtime_d >= cmp_d);
        if (push_ok_s && !pop_s)      count_d = count_q + CNT_ONE;
        else if (!push_ok_s && pop_s) count_d = count_q - CNT_ONE;
        else                          count_d = count_q;
        if (wr_tx_s && !push_ok_s)            ovf_d = 1'b1;
        else if (wr_stat_s && reg_wdata[3])   ovf_d = 1'b0;
        else                                  ovf_d = ovf_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (reg_ren) begin
            case (reg_raddr)
                A_GPIO_OUT: rdata_d = 32'(gpio_q);
                A_GPIO_IN:  rdata_d = 32'(gin_s2_q);
                A_MT_LO:    rdata_d = mtime_q[31:0];
                A_MT_HI:    rdata_d = mtime_q[63:32];
                A_CMP_LO:   rdata_d = cmp_q[31:0];
                A_CMP_HI:   rdata_d = cmp_q[63:32];
                A_TCTRL:    rdata_d = {30'd0, ie_q, en_q};
                A_UART_ST:  rdata_d = {24'd0, 4'(count_q), ovf_q, empty_s, full_s,
                                       (state_q != S_IDLE)};
                A_UART_DIV: rdata_d = {16'd0, div_q};
                default:    rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        bitidx_d = bitidx_q;
        shift_d  = shift_q;
        divlat_d = divlat_q;
        tx_d     = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    state_d  = S_START;
                    shift_d  = fifo_q[rptr_q];
                    divlat_d = div_eff_s;
                    bitcnt_d = div_eff_s - 16'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bitcnt_q == 16'd0) begin
                    state_d  = S_DATA;
                    bitcnt_d = divlat_q - 16'd1;
                    bitidx_d = 3'd0;
                end else begin
                    bitcnt_d = bitcnt_q - 16'd1;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bitcnt_q == 16'd0) begin
                    bitcnt_d = divlat_q - 16'd1;
                    shift_d  = {1'b0, shift_q[7:1]};
                    if (bitidx_q == 3'd7) state_d  = S_STOP;
                    else                  bitidx_d = bitidx_q + 3'd1;
                end else begin
                    bitcnt_d = bitcnt_q - 16'd1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bitcnt_q == 16'd0) state_d  = S_IDLE;
                else                   bitcnt_d = bitcnt_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            gpio_q   <= '0;
            gin_s1_q <= '0;
            gin_s2_q <= '0;
            mtime_q  <= 64'd0;
            cmp_q    <= {64{1'b1}};
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            irq_q    <= 1'b0;
            div_q    <= UART_DIV_RESET;
            rdata_q  <= 32'd0;
        end else begin
            gpio_q   <= gpio_d;
            gin_s1_q <= gpio_i;
            gin_s2_q <= gin_s1_q;
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            en_q     <= en_d;
            ie_q     <= ie_d;
            irq_q    <= irq_d;
            div_q    <= div_d;
            rdata_q  <= rdata_d;
        end
    end

    // FIFO storage and UART transmitter; the TX line is driven from the registered state
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 8'd0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            bitcnt_q <= 16'd0;
            bitidx_q <= 3'd0;
            shift_q  <= 8'd0;
            divlat_q <= 16'd1;
            tx_q     <= 1'b1;
        end else begin
            if (push_ok_s) begin
                fifo_q[wptr_q] <= reg_wdata[7:0];
                wptr_q         <= wptr_q + PTR_ONE;
            end
            if (pop_s) rptr_q <= rptr_q + PTR_ONE;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            bitidx_q <= bitidx_d;
            shift_q  <= shift_d;
            divlat_q <= divlat_d;
            tx_q     <= tx_d;
        end
    end

    assign reg_rdata   = rdata_q;
    assign gpio_o      = gpio_q;
    assign uart_tx_o   = tx_q;
    assign timer_irq_o = irq_q;

endmodule
